// File: rtl/game_timer.sv
// Elapsed mm:ss play timer for the sudoku game. Counts one second per level
// change of the divider output and flags expiry at a configurable limit.
module game_timer #(
    parameter int LIMIT_MIN = 99,
    parameter int LIMIT_SEC = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start,
    input  logic       pause,
    input  logic       finish,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       time_up,
    output logic [1:0] state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE,
        S_EXP
    } state_t;

    // Digit order in the packed vector: [3]=min_tens ... [0]=sec_ones.
    localparam logic [15:0] LIMIT_BCD = {4'(LIMIT_MIN / 10), 4'(LIMIT_MIN % 10),
                                         4'(LIMIT_SEC / 10), 4'(LIMIT_SEC % 10)};

    state_t          state_reg, state_next;
    logic            tick_d_reg;
    logic [3:0][3:0] digit_reg, digit_next, digit_inc;
    logic [3:0]      is_max;
    logic [3:0]      carry;
    logic            sec_evt;
    logic            at_max;

    assign sec_evt = tick_in ^ tick_d_reg;
    assign at_max  = &is_max;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] DMAX = (gi == 1 || gi == 3 && 0) ? 4'd5 : 4'd9;
            assign is_max[gi] = (digit_reg[gi] == DMAX);
            if (gi == 0) begin : g_lsd
                assign carry[gi] = 1'b1;
            end else begin : g_upper
                assign carry[gi] = &is_max[gi-1:0];
            end
            assign digit_inc[gi] = !carry[gi] ? digit_reg[gi] :
                                   (is_max[gi] ? 4'd0 : digit_reg[gi] + 4'd1);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        digit_next = digit_reg;
        if (clear) begin
            state_next = S_IDLE;
            digit_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_RUN;
                        digit_next = '0;
                    end
                end
                S_RUN: begin
                    // A same-cycle second is always counted; hitting the limit beats finish/pause.
                    if (sec_evt && !at_max) begin
                        digit_next = digit_inc;
                    end
                    if (sec_evt && !at_max && digit_inc == LIMIT_BCD) begin
                        state_next = S_EXP;
                    end else if (finish) begin
                        state_next = S_DONE;
                    end else if (pause) begin
                        state_next = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (finish) begin
                        state_next = S_DONE;
                    end else if (start && !pause) begin
                        state_next = S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        tick_d_reg <= tick_in;
        if (reset) begin
            state_reg <= S_IDLE;
            digit_reg <= '0;
        end else begin
            state_reg <= state_next;
            digit_reg <= digit_next;
        end
    end

    always_comb begin
        state = 2'd3;
        case (state_reg)
            S_IDLE:  state = 2'd0;
            S_RUN:   state = 2'd1;
            S_PAUSE: state = 2'd2;
            default: state = 2'd3;
        endcase
    end

    assign running  = (state_reg == S_RUN);
    assign time_up  = (state_reg == S_EXP);
    assign min_tens = digit_reg[3];
    assign min_ones = digit_reg[2];
    assign sec_tens = digit_reg[1];
    assign sec_ones = digit_reg[0];

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: two instances (default limit and 00:10 limit) share
// stimulus and are compared every cycle against an elapsed-seconds model.
module tb_game_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       finish = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] mt [2];
    logic [3:0] mo [2];
    logic [3:0] st [2];
    logic [3:0] so [2];
    logic       run_o [2];
    logic       tup_o [2];
    logic [1:0] state_o [2];

    int checks = 0;
    int errors = 0;

    // Model: states 0 idle, 1 run, 2 pause, 3 done, 4 expired.
    int m_secs [2] = '{0, 0};
    int m_st   [2] = '{0, 0};
    int m_lim  [2] = '{99 * 60 + 59, 10};
    logic m_tick_d = 1'b0;

    always #5 clk = ~clk;

    game_timer u_dut_def (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .pause(pause),
        .finish(finish), .clear(clear), .min_tens(mt[0]), .min_ones(mo[0]),
        .sec_tens(st[0]), .sec_ones(so[0]), .running(run_o[0]), .time_up(tup_o[0]),
        .state(state_o[0])
    );

    game_timer #(.LIMIT_MIN(0), .LIMIT_SEC(10)) u_dut_lim (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .pause(pause),
        .finish(finish), .clear(clear), .min_tens(mt[1]), .min_ones(mo[1]),
        .sec_tens(st[1]), .sec_ones(so[1]), .running(run_o[1]), .time_up(tup_o[1]),
        .state(state_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic evt;
        evt = (tick_in != m_tick_d);
        m_tick_d = tick_in;
        for (int i = 0; i < 2; i++) begin
            if (reset || clear) begin
                m_st[i] = 0;
                m_secs[i] = 0;
            end else begin
                case (m_st[i])
                    0: if (start) m_st[i] = 1;
                    1: begin
                        if (evt && m_secs[i] < 5999) begin
                            m_secs[i]++;
                            if (m_secs[i] == m_lim[i]) m_st[i] = 4;
                            else if (finish) m_st[i] = 3;
                            else if (pause) m_st[i] = 2;
                        end else if (finish) m_st[i] = 3;
                        else if (pause) m_st[i] = 2;
                    end
                    2: begin
                        if (finish) m_st[i] = 3;
                        else if (start && !pause) m_st[i] = 1;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int mins;
            int secs;
            mins = m_secs[i] / 60;
            secs = m_secs[i] % 60;
            check($sformatf("u%0d_min_tens", i), 32'(mt[i]), mins / 10);
            check($sformatf("u%0d_min_ones", i), 32'(mo[i]), mins % 10);
            check($sformatf("u%0d_sec_tens", i), 32'(st[i]), secs / 10);
            check($sformatf("u%0d_sec_ones", i), 32'(so[i]), secs % 10);
            check($sformatf("u%0d_state", i), 32'(state_o[i]), (m_st[i] >= 3) ? 3 : m_st[i]);
            check($sformatf("u%0d_running", i), 32'(run_o[i]), (m_st[i] == 1) ? 1 : 0);
            check($sformatf("u%0d_time_up", i), 32'(tup_o[i]), (m_st[i] == 4) ? 1 : 0);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic toggles(input int n, input int gap);
        repeat (n) begin
            tick_in = ~tick_in;
            cyc();
            repeat (gap - 1) cyc();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0; cyc();
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cyc(); pause = 1'b0; cyc();
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cyc(); clear = 1'b0; cyc();
    endtask

    task automatic report(input string phase);
        $display("%-12s def %0d%0d:%0d%0d st=%0d | lim %0d%0d:%0d%0d st=%0d up=%0d",
                 phase, mt[0], mo[0], st[0], so[0], state_o[0],
                 mt[1], mo[1], st[1], so[1], state_o[1], tup_o[1]);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        report("reset");

        pulse_start();
        toggles(75, 10);
        report("basic");
        pulse_clear();

        toggles(5, 3);
        pulse_start();
        toggles(3, 3);
        pulse_pause();
        toggles(4, 3);
        pulse_start();
        toggles(1, 3);
        report("gating");
        pulse_clear();

        pulse_start();
        toggles(10, 2);
        toggles(5, 2);
        pulse_start();
        report("limit");
        pulse_clear();

        pulse_start();
        toggles(3600, 1);
        report("carry");
        pulse_clear();

        pulse_start();
        toggles(150, 1);
        finish = 1'b1; tick_in = ~tick_in; cyc(); finish = 1'b0; cyc();
        toggles(3, 2);
        pulse_start();
        report("finish");
        clear = 1'b1; tick_in = ~tick_in; cyc(); clear = 1'b0; cyc();
        report("clear_tick");

        pulse_start();
        toggles(187, 1);
        reset = 1'b1; tick_in = ~tick_in; cyc(); reset = 1'b0; cyc();
        toggles(1, 3);
        pulse_start();
        repeat (4) cyc();
        toggles(1, 3);
        report("reset_mid");

        repeat (3000) begin
            if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
            start  = ($urandom_range(0, 19) == 0);
            pause  = ($urandom_range(0, 29) == 0);
            finish = ($urandom_range(0, 199) == 0);
            clear  = ($urandom_range(0, 299) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            cyc();
        end
        start = 1'b0; pause = 1'b0; finish = 1'b0; clear = 1'b0; reset = 1'b0;
        cyc();
        report("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
